// File: rtl/three_pkg.sv
// Shared widths, select type and helpers for the registered 4-to-16 decoder.
package three_pkg;

  localparam int SEL_W = 4;
  localparam int OUT_W = 16;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic is_onehot(input logic [OUT_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/dec2to4.sv
// Combinational 2-to-4 decoder with enable; d[0] is asserted for a == 0.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [0:3] d
);

  always_comb begin
    d = '0;
    if (en) d[a] = 1'b1;
  end

endmodule

// File: rtl/three_dec.sv
// Registered 4-to-16 one-hot decoder built as a two-level dec2to4 tree.
// Define THREE_ONEHOT_CHECK_EN to add the err output and its one-hot checker.
module three_dec
  import three_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SEL_W-1:0] w,
  output logic [0:OUT_W-1] y
`ifdef THREE_ONEHOT_CHECK_EN
  ,
  output logic             err
`endif
);

  sel_t             sel;
  logic [0:3]       grp_en;
  logic [0:OUT_W-1] y_next;

  assign sel = w;

  dec2to4 u_pre (
    .en (en),
    .a  (sel[3:2]),
    .d  (grp_en)
  );

  // Group g covers y[4g..4g+3], so ascending slices keep y[0] as code 0.
  for (genvar g = 0; g < 4; g++) begin : g_grp
    dec2to4 u_grp (
      .en (grp_en[g]),
      .a  (sel[1:0]),
      .d  (y_next[4*g +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y <= '0;
    else        y <= y_next;
  end

`ifdef THREE_ONEHOT_CHECK_EN
  logic en_q;

  // The enable that produced the current y decides which shape y must have.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      err  <= 1'b0;
    end else begin
      en_q <= en;
      err  <= en_q ? !is_onehot(y) : (y != '0);
    end
  end
`endif

endmodule

// File: tb/tb_three_dec.sv
// Self-checking bench for three_dec: vector table plus hand sequences, scoreboard queue.
// Covers the err checker as well when THREE_ONEHOT_CHECK_EN is defined.
module tb_three_dec;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  w;
  logic [0:15] y;
`ifdef THREE_ONEHOT_CHECK_EN
  logic        err;
`endif

  three_dec dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .w     (w),
    .y     (y)
`ifdef THREE_ONEHOT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        en;
    logic [3:0]  w;
    logic [15:0] exp_y;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          tests_run;
  int          tests_failed;

  // Independent model: bit i of y[0:15] is weight 2^(15-i) in a [15:0] word.
  function automatic logic [15:0] model(input logic r, input logic e, input logic [3:0] sel);
    if (!r || !e) return 16'h0000;
    return 16'h8000 >> sel;
  endfunction

  task automatic checkOutput(input string name);
    logic [15:0] exp_y;
    logic [15:0] act_y;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: scoreboard empty, y=%h", name, y);
      return;
    end
    exp_y = exp_q.pop_front();
    act_y = y;
    if (act_y !== exp_y) begin
      tests_failed++;
      $display("[TB] FAIL %s: y=%h expected %h", name, act_y, exp_y);
    end
`ifdef THREE_ONEHOT_CHECK_EN
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s_err: err=%b expected 0", name, err);
    end
`endif
  endtask

  task automatic applyStimulus(input string name, input logic r, input logic e,
                               input logic [3:0] sel, input logic [15:0] exp_y);
    rst_n = r;
    en    = e;
    w     = sel;
    exp_q.push_back(exp_y);
    @(posedge clk);
    #1;
    checkOutput(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, timeout expected none");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    w     = 4'd0;

    vecs.push_back('{"reset0",   1'b0, 1'b1, 4'd5,    16'h0000});
    vecs.push_back('{"reset1",   1'b0, 1'b1, 4'd5,    16'h0000});
    vecs.push_back('{"release5", 1'b1, 1'b1, 4'd5,    16'h0400});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{$sformatf("sweep%0d", i), 1'b1, 1'b1, 4'(i), model(1'b1, 1'b1, 4'(i))});
    vecs.push_back('{"disable",  1'b1, 1'b0, 4'b1001, 16'h0000});
    vecs.push_back('{"reen9",    1'b1, 1'b1, 4'd9,    16'h0040});
    vecs.push_back('{"b2b_3",    1'b1, 1'b1, 4'd3,    16'h1000});
    vecs.push_back('{"b2b_12",   1'b1, 1'b1, 4'd12,   16'h0008});
    vecs.push_back('{"b2b_3b",   1'b1, 1'b1, 4'd3,    16'h1000});
    vecs.push_back('{"dis_f",    1'b1, 1'b0, 4'd15,   16'h0000});

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].name, vecs[i].rst_n, vecs[i].en, vecs[i].w, vecs[i].exp_y);

    // Mid-stream reset must clear y on the edge it is sampled and resume after.
    applyStimulus("mid_pre",  1'b1, 1'b1, 4'd7, 16'h0100);
    applyStimulus("mid_rst",  1'b0, 1'b1, 4'd7, 16'h0000);
    applyStimulus("mid_post", 1'b1, 1'b1, 4'd7, 16'h0100);

    // Inputs wiggling between edges must not matter.
    rst_n = 1'b1;
    en    = 1'b0;
    w     = 4'd2;
    #2;
    en    = 1'b1;
    w     = 4'd14;
    exp_q.push_back(model(1'b1, 1'b1, 4'd14));
    @(posedge clk);
    #3;
    w     = 4'd1;
    en    = 1'b0;
    #1;
    checkOutput("between_edges");

`ifdef THREE_ONEHOT_CHECK_EN
    en = 1'b1;
    w  = 4'd4;
    @(posedge clk);
    #1;
    force dut.y = 16'hC000;
    @(posedge clk);
    #1;
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_forced: err=%b expected 1", err);
    end
    release dut.y;
    exp_q.delete();
    applyStimulus("err_clr_rst", 1'b0, 1'b1, 4'd4, 16'h0000);
    applyStimulus("err_after",   1'b1, 1'b1, 4'd4, 16'h0800);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
